// File: rtl/rule110_seed_loader.sv
// rtl/rule110_seed_loader.sv - byte-stream seed assembler feeding the rule110 automaton
//
// Collects WIDTH/8 bytes MSB-first into a seed register, then offers the seed
// over a valid/ready handshake. The seed register is kept after a handshake, so
// seed_out holds its last value until the next fill shifts new bytes in.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active-high
//   clear       synchronous abort; drops any partial or pending seed
//   byte_in     seed byte
//   byte_valid  byte_in is valid this cycle
//   byte_ready  loader can accept a byte this cycle
//   seed_out    assembled seed; first byte received sits in [WIDTH-1:WIDTH-8]
//   seed_valid  seed_out holds a complete seed
//   seed_ready  automaton consumes seed_out this cycle
//   load_count  bytes accepted in the current fill, 0..NBYTES
//   busy        high while filling or presenting a seed
module rule110_seed_loader #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [WIDTH-1:0] seed_out,
  output logic             seed_valid,
  input  logic             seed_ready,
  output logic [CNT_W-1:0] load_count,
  output logic             busy
);

  localparam int NBYTES = WIDTH / 8;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] count_q;

  logic accept;
  logic last_byte;
  logic handshake;

  // Outputs are decoded straight from registered state so they never depend
  // on same-cycle inputs.
  assign byte_ready = (state != PRESENT);
  assign seed_valid = (state == PRESENT);
  assign busy       = (state != IDLE);
  assign seed_out   = shift_q;
  assign load_count = count_q;

  assign accept    = byte_valid & byte_ready;
  assign last_byte = accept & (count_q == LAST_IDX);
  assign handshake = seed_valid & seed_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = last_byte ? PRESENT : FILL;
        end
      end
      FILL: begin
        if (last_byte) begin
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (seed_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // clear wins over any accept or handshake in the same cycle
    if (clear) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (handshake) begin
      // seed register deliberately retained; only the fill count restarts
      count_q <= '0;
    end else if (accept) begin
      shift_q <= {shift_q[WIDTH-9:0], byte_in};
      count_q <= count_q + 1'b1;
    end
  end

endmodule
